rr_grant_ctrl4: RTL and testbench
=================================

Name: rr_grant_ctrl4

Overview:
- Four-requester round-robin arbiter that sequences a shared 4-way resource.
- Produces a registered 2-bit select `sel` and its one-hot decode `gnt[3:0]`, so exactly one requester owns the resource at a time.
- Sits between requesting units and the select input of the shared datapath. Enforces a bounded hold time and a one-cycle turnaround between owners.

Parameters:
- HOLD_MAX, 16, maximum consecutive cycles one owner may keep the grant while other requests are pending; legal range 2..256.
- CW, $clog2(HOLD_MAX), width of the hold counter; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- req  in  4  request vector; requester i holds req[i] high for as long as it needs the resource.
- sel  out  2  index of current or last owner; drives the shared resource select.
- gnt  out  4  one-hot grant; all-zero when no owner.
- gnt_valid  out  1  high exactly when gnt is non-zero.
- preempt  out  1  one-cycle pulse when the owner loses the grant by timeout.

Behaviour:
- Reset (rst_n low at an edge): state=IDLE, ptr=0, sel=0, gnt=0, gnt_valid=0, preempt=0, hold_cnt=0. Reset overrides any operation in progress; the grant is dropped on that same edge.
- All outputs are registered; no combinational path from req to any output.
- States: IDLE, GRANT, GAP.
- Pick function: the first i with req[i]=1, scanning ptr, ptr+1, ... mod 4.
- IDLE:
  - If req != 0, go to GRANT.
  - On the same edge: sel=pick, gnt=onehot(pick), gnt_valid=1, hold_cnt=0.
  - Latency from req rising to gnt high is 1 clock.
- GRANT, each edge:
  - Release: if req[sel]=0, go to GAP; gnt=0, gnt_valid=0, ptr=sel+1 (mod 4).
  - Timeout: else if hold_cnt==HOLD_MAX-1 and (req & ~onehot(sel)) != 0, go to GAP; gnt=0, ptr=sel+1, preempt=1 for that cycle only.
  - Otherwise: stay in GRANT; hold_cnt increments and saturates at HOLD_MAX-1. If no other requester is pending at saturation, the owner keeps the grant indefinitely.
- GAP (exactly 1 cycle, gnt=0):
  - If req != 0, go to GRANT with pick from the new ptr; hold_cnt=0.
  - Else go to IDLE.
  - A released owner re-granted through GAP sees gnt low for at least 1 cycle.
- sel holds its last value while in GAP and IDLE.
- Simultaneous events:
  - If release and timeout coincide, it is treated as a release (preempt stays 0).
  - All requests arriving in the same cycle are resolved by ptr order only.
- Fairness: with all four requesting continuously, grants rotate 0,1,2,3,0,... Each tenure is HOLD_MAX cycles, followed by a 1-cycle gap.
- Invariants: gnt is always 0 or one-hot; gnt==onehot(sel) whenever gnt_valid=1.

Decomposition:
- Shared package holds:
  - state enum {IDLE, GRANT, GAP}, 2-bit encoding;
  - constant N_REQ=4;
  - a function rr_pick(req, ptr) returning a 2-bit index.
- One natural sub-module: dec2to4, a 2-to-4 one-hot decoder that computes the next gnt from the next sel.

Test Plan (HOLD_MAX=4 unless stated):
- Reset then idle: rst_n low 2 cycles, req=0 -> gnt=0, sel=0, gnt_valid=0, preempt=0 throughout.
- Single requester: req=4'b0100 set at cycle 0 -> gnt=4'b0100, sel=2 from cycle 1. Drop req at cycle 5 -> gnt=0 at cycle 6, state IDLE at cycle 7.
- Rotation: req=4'b1111 held, HOLD_MAX=4 -> owners 0,1,2,3,0. Each owner holds 4 cycles, followed by 1 gap cycle, and a preempt pulse at each handover.
- Lone owner no preempt: req=4'b0001 held 20 cycles -> gnt=4'b0001 continuously, preempt never asserted.
- Release/timeout tie: owner 1 drops req on the cycle hold_cnt reaches 3 while req[2]=1 -> preempt=0, gap 1 cycle, then gnt=4'b0100.
- Mid-grant reset: rst_n low during owner 3's tenure -> gnt=0 on that edge. After release, req=4'b1001 -> grant goes to 0 (ptr reset to 0).

Source files
------------

// File: rtl/rr_grant_ctrl4_pkg.sv
// ============================================================================
// Module   : rr_grant_ctrl4_pkg
// Brief    : Shared state encoding, requester count and round-robin pick.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rr_grant_ctrl4_pkg;

    localparam int N_REQ = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    // First set request scanning ptr, ptr+1, ... (mod 4); returns ptr when req is empty.
    function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] req,
                                           input logic [1:0]       ptr);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_grant_ctrl4_dec2to4.sv
// ============================================================================
// Module   : rr_grant_ctrl4_dec2to4
// Brief    : Enabled 2-to-4 one-hot decoder producing the next grant vector.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_grant_ctrl4_dec2to4
    import rr_grant_ctrl4_pkg::*;
(
    input  logic [1:0]       sel_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] onehot_o
);

    for (genvar i = 0; i < N_REQ; i++) begin : g_dec
        assign onehot_o[i] = en_i && (sel_i == 2'(i));
    end

endmodule

`default_nettype wire

// File: rtl/rr_grant_ctrl4.sv
// ============================================================================
// Module   : rr_grant_ctrl4
// Brief    : Four-requester round-robin arbiter with bounded hold time and a
//            one-cycle turnaround gap between owners; all outputs registered.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_grant_ctrl4
    import rr_grant_ctrl4_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_i,
    output logic [1:0]       sel_o,
    output logic [N_REQ-1:0] gnt_o,
    output logic             gnt_valid_o,
    output logic             preempt_o
);

    localparam int            CW        = $clog2(HOLD_MAX);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       sel_q, sel_d;
    logic [CW-1:0]    hold_q, hold_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             valid_q, valid_d;
    logic             preempt_q, preempt_d;
    logic             others_pending;

    // gnt_q equals onehot(sel_q) while in GRANT, so it masks out the owner.
    assign others_pending = |(req_i & ~gnt_q);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        hold_d    = hold_q;
        valid_d   = 1'b0;
        preempt_d = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                if (|req_i) begin
                    state_d = GRANT;
                    sel_d   = rr_pick(req_i, ptr_q);
                    hold_d  = '0;
                    valid_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (!req_i[sel_q]) begin
                    state_d = GAP;
                    ptr_d   = sel_q + 2'd1;
                end else if ((hold_q == HOLD_LAST) && others_pending) begin
                    state_d   = GAP;
                    ptr_d     = sel_q + 2'd1;
                    preempt_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    if (hold_q != HOLD_LAST) begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    rr_grant_ctrl4_dec2to4 u_dec (
        .sel_i    (sel_d),
        .en_i     (valid_d),
        .onehot_o (gnt_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            sel_q     <= 2'd0;
            hold_q    <= '0;
            gnt_q     <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            valid_q   <= valid_d;
            preempt_q <= preempt_d;
        end
    end

    assign sel_o       = sel_q;
    assign gnt_o       = gnt_q;
    assign gnt_valid_o = valid_q;
    assign preempt_o   = preempt_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_grant_ctrl4.sv
// ============================================================================
// Module   : tb_rr_grant_ctrl4
// Brief    : Directed scoreboard bench for rr_grant_ctrl4 with HOLD_MAX=4.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rr_grant_ctrl4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic       preempt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         due;
        string      name;
        logic [1:0] sel;
        logic [3:0] gnt;
        logic       v;
        logic       p;
    } exp_t;

    exp_t sb[$];

    rr_grant_ctrl4 #(.HOLD_MAX(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .sel_o       (sel),
        .gnt_o       (gnt),
        .gnt_valid_o (gnt_valid),
        .preempt_o   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Drive one cycle of inputs; the response is due after the next edge.
    task automatic step(input string name, input logic r, input logic [3:0] rq,
                        input logic [1:0] es, input logic [3:0] eg,
                        input logic ev, input logic ep);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r;
        req   = rq;
        e.due  = cyc + 1;
        e.name = name;
        e.sel  = es;
        e.gnt  = eg;
        e.v    = ev;
        e.p    = ep;
        sb.push_back(e);
    endtask

    // Monitor: compares every response that falls due on this edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.due != cyc || sel !== e.sel || gnt !== e.gnt ||
                    gnt_valid !== e.v || preempt !== e.p) begin
                    errors++;
                    $display("FAIL %s cyc=%0d: got sel=%0d gnt=%b v=%b p=%b, want sel=%0d gnt=%b v=%b p=%b",
                             e.name, cyc, sel, gnt, gnt_valid, preempt,
                             e.sel, e.gnt, e.v, e.p);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;

        // Reset then idle
        step("reset0", 0, 4'b0000, 2'd0, 4'b0000, 0, 0);
        step("reset1", 0, 4'b0000, 2'd0, 4'b0000, 0, 0);
        step("idle0",  1, 4'b0000, 2'd0, 4'b0000, 0, 0);
        step("idle1",  1, 4'b0000, 2'd0, 4'b0000, 0, 0);

        // Single requester 2, then release (ptr -> 3)
        step("single_grant", 1, 4'b0100, 2'd2, 4'b0100, 1, 0);
        for (int i = 0; i < 4; i++)
            step("single_hold", 1, 4'b0100, 2'd2, 4'b0100, 1, 0);
        step("single_release", 1, 4'b0000, 2'd2, 4'b0000, 0, 0);
        step("single_gap",     1, 4'b0000, 2'd2, 4'b0000, 0, 0);
        step("single_idle",    1, 4'b0000, 2'd2, 4'b0000, 0, 0);

        // Rotation from ptr 0: 4 grant cycles then a preempting gap per owner
        step("rot_reset", 0, 4'b0000, 2'd0, 4'b0000, 0, 0);
        for (int o = 0; o < 5; o++) begin
            for (int i = 0; i < 4; i++)
                step("rot_grant", 1, 4'b1111, 2'(o % 4), 4'(1 << (o % 4)), 1, 0);
            step("rot_preempt", 1, 4'b1111, 2'(o % 4), 4'b0000, 0, 1);
        end

        // Lone owner 0 (from GAP, ptr 1) held 20 cycles without preempt
        for (int i = 0; i < 20; i++)
            step("lone_hold", 1, 4'b0001, 2'd0, 4'b0001, 1, 0);
        // Saturated counter: a late competitor causes an immediate timeout
        step("late_preempt", 1, 4'b0011, 2'd0, 4'b0000, 0, 1);
        step("late_grant",   1, 4'b0011, 2'd1, 4'b0010, 1, 0);
        step("late_release", 1, 4'b0000, 2'd1, 4'b0000, 0, 0);
        step("late_idle",    1, 4'b0000, 2'd1, 4'b0000, 0, 0);

        // Release/timeout tie: ptr 2, owner 1 drops req when hold reaches 3
        step("tie_grant", 1, 4'b0010, 2'd1, 4'b0010, 1, 0);
        for (int i = 0; i < 3; i++)
            step("tie_hold", 1, 4'b0110, 2'd1, 4'b0010, 1, 0);
        step("tie_release", 1, 4'b0100, 2'd1, 4'b0000, 0, 0);
        step("tie_next",    1, 4'b0100, 2'd2, 4'b0100, 1, 0);
        step("tie_drop",    1, 4'b0000, 2'd2, 4'b0000, 0, 0);
        step("tie_idle",    1, 4'b0000, 2'd2, 4'b0000, 0, 0);

        // Mid-grant reset: owner 3 (ptr 3), reset drops grant and clears ptr
        step("mid_grant",   1, 4'b1000, 2'd3, 4'b1000, 1, 0);
        step("mid_hold",    1, 4'b1000, 2'd3, 4'b1000, 1, 0);
        step("mid_reset",   0, 4'b1000, 2'd0, 4'b0000, 0, 0);
        step("mid_idle",    1, 4'b0000, 2'd0, 4'b0000, 0, 0);
        step("mid_regrant", 1, 4'b1001, 2'd0, 4'b0001, 1, 0);
        step("mid_hold2",   1, 4'b1001, 2'd0, 4'b0001, 1, 0);
        step("mid_release", 1, 4'b0000, 2'd0, 4'b0000, 0, 0);

        repeat (3) @(posedge clk);
        #5;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses pending, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
